// File: rtl/traffic_intersection_ctrl.sv
// Fixed-time intersection controller. It rotates green among N_DIR approaches, separated by yellow and all-red clearance.
// It also handles pedestrian green extension and a flashing-red fail-safe mode.
module traffic_intersection_ctrl #(
    parameter int N_DIR      = 2,
    parameter int GREEN_T    = 8,
    parameter int YELLOW_T   = 3,
    parameter int RED_CLR    = 2,
    parameter int PED_EXT    = 4,
    parameter int FLASH_HALF = 2,
    parameter int TIMER_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_DIR-1:0]     ped_req_i,
    input  logic                 flash_en_i,
    output logic [3*N_DIR-1:0]   lights_o,
    output logic [N_DIR-1:0]     walk_o,
    output logic [1:0]           active_dir_o,
    output logic                 flashing_o
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] RED_LAST   = TIMER_W'(RED_CLR - 1);
    localparam logic [TIMER_W-1:0] GREEN_LAST = TIMER_W'(GREEN_T - 1);
    localparam logic [TIMER_W-1:0] EXT_LAST   = TIMER_W'(GREEN_T + PED_EXT - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST   = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(FLASH_HALF - 1);
    localparam logic [1:0]         DIR_LAST   = 2'(N_DIR - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         dir_q, dir_d;
    logic [N_DIR-1:0]   pend_q, pend_d;
    logic               ext_q, ext_d;
    logic               flash_on_q, flash_on_d;
    logic [N_DIR-1:0]   dir_oh_s;
    logic [TIMER_W-1:0] green_last_s;

    // One-hot mask of the approach owning the current rotation slot.
    always_comb begin
        dir_oh_s = '0;
        for (int d = 0; d < N_DIR; d++) begin
            dir_oh_s[d] = (dir_q == 2'(d));
        end
    end

    assign green_last_s = ext_q ? EXT_LAST : GREEN_LAST;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ALL_RED;
            timer_q    <= '0;
            dir_q      <= 2'd0;
            pend_q     <= '0;
            ext_q      <= 1'b0;
            flash_on_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            ext_q      <= ext_d;
            flash_on_q <= flash_on_d;
        end
    end

    // Next-state logic; a request that lands on the green-entry edge counts as served.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TIMER_W'(1);
        dir_d      = dir_q;
        ext_d      = ext_q;
        flash_on_d = flash_on_q;
        pend_d     = pend_q | ped_req_i;
        case (state_q)
            ST_ALL_RED: begin
                if (flash_en_i) begin
                    state_d    = ST_FLASH;
                    timer_d    = '0;
                    flash_on_d = 1'b1;
                end else if (timer_q == RED_LAST) begin
                    state_d = ST_GREEN;
                    timer_d = '0;
                    ext_d   = |(pend_d & dir_oh_s);
                    pend_d  = pend_d & ~dir_oh_s;
                end else begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_GREEN: begin
                if (flash_en_i || (timer_q == green_last_s)) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                end else begin
                    state_d = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                if (timer_q == YEL_LAST) begin
                    timer_d = '0;
                    if (flash_en_i) begin
                        state_d    = ST_FLASH;
                        flash_on_d = 1'b1;
                    end else begin
                        state_d = ST_ALL_RED;
                        dir_d   = (dir_q == DIR_LAST) ? 2'd0 : dir_q + 2'd1;
                    end
                end else begin
                    state_d = ST_YELLOW;
                end
            end
            ST_FLASH: begin
                if (!flash_en_i) begin
                    state_d    = ST_ALL_RED;
                    timer_d    = '0;
                    dir_d      = 2'd0;
                    flash_on_d = 1'b1;
                end else if (timer_q == FLASH_LAST) begin
                    timer_d    = '0;
                    flash_on_d = ~flash_on_q;
                end else begin
                    state_d = ST_FLASH;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = '0;
            end
        endcase
    end

    // Output decode straight from registered state.
    always_comb begin
        lights_o     = '0;
        walk_o       = '0;
        active_dir_o = dir_q;
        flashing_o   = (state_q == ST_FLASH);
        for (int d = 0; d < N_DIR; d++) begin
            case (state_q)
                ST_ALL_RED: lights_o[3*d +: 3] = 3'b100;
                ST_GREEN:   lights_o[3*d +: 3] = dir_oh_s[d] ? 3'b001 : 3'b100;
                ST_YELLOW:  lights_o[3*d +: 3] = dir_oh_s[d] ? 3'b010 : 3'b100;
                ST_FLASH:   lights_o[3*d +: 3] = flash_on_q ? 3'b100 : 3'b000;
                default:    lights_o[3*d +: 3] = 3'b100;
            endcase
        end
        if ((state_q == ST_GREEN) && ext_q) begin
            walk_o = dir_oh_s;
        end else begin
            walk_o = '0;
        end
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 The block SHALL expose parameter N_DIR, default 2, meaning number of approaches served in rotation (legal 2..4).
REQ-002 The block SHALL expose parameter GREEN_T, default 8, meaning green duration in cycles (>=1).
REQ-003 The block SHALL expose parameter YELLOW_T, default 3, meaning yellow duration in cycles (>=1).
REQ-004 The block SHALL expose parameter RED_CLR, default 2, meaning all-red clearance duration in cycles (>=1).
REQ-005 The block SHALL expose parameter PED_EXT, default 4, meaning extra green cycles granted when a pedestrian request is served (>=0).
REQ-006 The block SHALL expose parameter FLASH_HALF, default 2, meaning half-period of the flashing-red pattern in cycles (>=1).
REQ-007 The block SHALL expose parameter TIMER_W, default 8, meaning phase timer width; it must hold max(GREEN_T+PED_EXT, YELLOW_T, RED_CLR, FLASH_HALF)-1.
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 ped_req  input  N_DIR  per-approach pedestrian request, one-cycle pulse or level.
REQ-011 flash_en  input  1  request for flashing-red fail-safe mode.
REQ-012 lights  output  3*N_DIR  per approach d, bits [3d+2:3d] = {Red,Yellow,Green}, exactly one-hot except flash-off phase.
REQ-013 walk  output  N_DIR  walk indication per approach.
REQ-014 active_dir  output  2  index of approach currently owning or next owning green.
REQ-015 flashing  output  1  high while in FLASH state.

Function
REQ-016 The FSM SHALL have states ALL_RED, GREEN, YELLOW, FLASH; outputs SHALL be decoded combinationally from registered state, no added latency.
REQ-017 Each timed state SHALL last exactly its duration D cycles: timer counts 0..D-1, transition and timer clear when timer==D-1.
REQ-018 Sequence: ALL_RED(RED_CLR) -> GREEN(active_dir) -> YELLOW(active_dir) -> ALL_RED; on YELLOW->ALL_RED, active_dir SHALL advance to (active_dir+1) mod N_DIR.
REQ-019 During GREEN/YELLOW only approach active_dir SHALL show Green/Yellow; every other approach SHALL show Red; in ALL_RED all approaches show Red.
REQ-020 ped_req[d] SHALL set sticky pend[d]; pend[d] SHALL clear on the cycle GREEN for d is entered, and that GREEN SHALL last GREEN_T+PED_EXT cycles with walk[d]=1 for its full duration.
REQ-021 ped_req[d] arriving while d is already GREEN or YELLOW SHALL remain pending for d's next green, not extend the current one.
REQ-022 Simultaneous ped_req[d] and green entry for d SHALL be treated as served (pend[d] ends 0, extension granted).
REQ-023 walk SHALL be 0 outside GREEN.
REQ-024 flash_en high during GREEN SHALL move to YELLOW next cycle (green truncated); during YELLOW the yellow SHALL complete; from ALL_RED it SHALL enter FLASH next cycle; YELLOW completion with flash_en high SHALL enter FLASH instead of ALL_RED.
REQ-025 In FLASH all Red bits SHALL be 1 for FLASH_HALF cycles then 0 for FLASH_HALF cycles, repeating, starting with on; Yellow/Green/walk SHALL be 0; pend SHALL keep accumulating.
REQ-026 flash_en low in FLASH SHALL enter ALL_RED next cycle with timer=0 and active_dir=0.
REQ-027 Timer SHALL never wrap; it SHALL clear on every state change.

Reset
REQ-028 rst_n low SHALL immediately force state=ALL_RED, timer=0, active_dir=0, pend=0, so lights=all Red, walk=0, flashing=0.
REQ-029 Reset asserted mid-phase SHALL abandon the phase; first phase after release SHALL be a full RED_CLR clearance then GREEN for approach 0.

Verification
REQ-030 Defaults, release reset, no requests -> cycles 0-1 all Red, 2-9 dir0 Green, 10-12 dir0 Yellow, 13-14 all Red, 15-22 dir1 Green, dir0 Green again at cycle 28.
REQ-031 ped_req[1] pulse at cycle 5 -> dir1 Green cycles 15-26 (12 cycles) with walk[1]=1 exactly those cycles, pend[1] clear at 15.
REQ-032 ped_req[0] at cycle 4 (dir0 Green) -> dir0 green cycles 2-9 unextended; next dir0 green at 28 lasts 12 cycles with walk[0]=1.
REQ-033 flash_en high at cycle 4 -> Yellow cycles 5-7, FLASH from 8, Red bits on 8-9, off 10-11, on 12-13; flash_en low at 13 -> ALL_RED at 14, dir0 Green at 16.
REQ-034 rst_n low at cycle 20 (dir1 Green) -> lights all Red same cycle; after release, all Red 2 cycles then dir0 Green.
REQ-035 N_DIR=4 instance, no requests -> Green rotates 0,1,2,3,0 with period 52 cycles and never two approaches non-Red simultaneously.
